// File: rtl/phone_command_rx_if.sv
// UART-side handshake between the phone command receiver and its byte-level UART.
// The slave modport is the command receiver; master is the UART (or a bench standing in for it).
interface phone_command_rx_if;
  logic       received;
  logic [7:0] rx_byte;
  logic       is_transmitting;
  logic       transmit;
  logic [7:0] tx_byte;

  modport master (
    output received, rx_byte, is_transmitting,
    input  transmit, tx_byte
  );

  modport slave (
    input  received, rx_byte, is_transmitting,
    output transmit, tx_byte
  );
endinterface

// File: rtl/phone_command_rx.sv
// Parses SYNC/CMD/DH/DL/CHK packets from the phone, updates the motor command outputs
// and answers each packet (or inter-byte timeout) with a one-byte ACK/NAK.
module phone_command_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  phone_command_rx_if.slave       uart,
  output logic [9:0]              SpeedSetpoint,
  output logic [1:0]              Mode,
  output logic                    Stop,
  output logic                    CmdValid,
  output logic                    CmdError
);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_DH, GET_DL, GET_CHK} parseState_t;

  parseState_t   state;
  logic [TW-1:0] timeoutCount;
  logic [7:0]    cmdByte;
  logic [7:0]    dataHigh;
  logic [7:0]    dataLow;
  logic          pending;
  logic [7:0]    pendingByte;
  logic          transmitReg;
  logic [7:0]    txByteReg;

  logic timeoutHit;
  logic packetDone;
  logic chkOk;
  logic cmdKnown;
  logic accept;
  logic reject;

  // A byte arriving in the same cycle as the timeout wins, hence the !received term.
  always_comb begin
    timeoutHit = (state != IDLE) && !uart.received && (timeoutCount == TIMEOUT_LAST);
    packetDone = (state == GET_CHK) && uart.received;
    chkOk      = (uart.rx_byte == (cmdByte ^ dataHigh ^ dataLow));
    cmdKnown   = (cmdByte == 8'h01) || (cmdByte == 8'h02) || (cmdByte == 8'h03);
    accept     = packetDone && chkOk && cmdKnown;
    reject     = (packetDone && !(chkOk && cmdKnown)) || timeoutHit;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state         <= IDLE;
      timeoutCount  <= '0;
      cmdByte       <= 8'h00;
      dataHigh      <= 8'h00;
      dataLow       <= 8'h00;
      pending       <= 1'b0;
      pendingByte   <= 8'h00;
      transmitReg   <= 1'b0;
      txByteReg     <= 8'h00;
      SpeedSetpoint <= 10'd0;
      Mode          <= 2'b00;
      Stop          <= 1'b1;
      CmdValid      <= 1'b0;
      CmdError      <= 1'b0;
    end else begin
      CmdValid <= accept;
      CmdError <= reject;

      if (uart.received || state == IDLE || timeoutHit)
        timeoutCount <= '0;
      else
        timeoutCount <= timeoutCount + 1'b1;

      if (timeoutHit) begin
        state <= IDLE;
      end else if (uart.received) begin
        // SYNC_BYTE only matters in IDLE; inside a packet it is ordinary data.
        case (state)
          IDLE:    if (uart.rx_byte == SYNC_BYTE) state <= GET_CMD;
          GET_CMD: begin cmdByte  <= uart.rx_byte; state <= GET_DH;  end
          GET_DH:  begin dataHigh <= uart.rx_byte; state <= GET_DL;  end
          GET_DL:  begin dataLow  <= uart.rx_byte; state <= GET_CHK; end
          default: state <= IDLE;
        endcase
      end

      if (accept) begin
        case (cmdByte)
          8'h01: begin
            SpeedSetpoint <= {dataHigh[1:0], dataLow};
            Stop          <= 1'b0;
          end
          8'h02:   Mode <= dataLow[1:0];
          8'h03: begin
            Stop          <= 1'b1;
            SpeedSetpoint <= 10'd0;
          end
          default: ;
        endcase
      end

      // The !transmitReg term forces an idle cycle so the UART can raise is_transmitting.
      transmitReg <= 1'b0;
      if (pending && !uart.is_transmitting && !transmitReg) begin
        transmitReg <= 1'b1;
        txByteReg   <= pendingByte;
        pending     <= 1'b0;
      end
      // A fresh result overrides the launch above: latest result wins the single slot.
      if (accept || reject) begin
        pending     <= 1'b1;
        pendingByte <= accept ? ACK : NAK;
      end
    end
  end

  assign uart.transmit = transmitReg;
  assign uart.tx_byte  = txByteReg;
endmodule

// File: tb/tb_phone_command_rx.sv
// Scoreboard bench for phone_command_rx: stimulus pushes expected results/acks,
// a negedge monitor pops and compares whenever the DUT pulses a result or transmit.
module tb_phone_command_rx;
  localparam int TO = 100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  phone_command_rx_if bus();
  logic [9:0] speed;
  logic [1:0] mode;
  logic       stop;
  logic       cmdValid;
  logic       cmdError;

  phone_command_rx #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .uart          (bus.slave),
    .SpeedSetpoint (speed),
    .Mode          (mode),
    .Stop          (stop),
    .CmdValid      (cmdValid),
    .CmdError      (cmdError)
  );

  typedef struct {
    bit         isError;
    logic [9:0] speed;
    logic [1:0] mode;
    logic       stop;
    int         cyc;
  } result_t;

  result_t    resQ[$];
  logic [7:0] txQ[$];
  result_t    monR;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int uartBusy = 0;
  bit holdTx = 1'b0;
  bit queueAck = 1'b1;
  bit prevTx = 1'b0;
  logic [9:0] mSpeed = 10'd0;
  logic [1:0] mMode = 2'd0;
  logic       mStop = 1'b1;

  // Minimal UART model: busy for three cycles after each transmit strobe.
  assign bus.is_transmitting = holdTx || (uartBusy != 0);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.transmit) uartBusy <= 3;
    else if (uartBusy != 0) uartBusy <= uartBusy - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic failNow(input string msg);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  always @(negedge clk) begin
    if (cmdValid || cmdError) begin
      if (resQ.size() == 0) begin
        failNow($sformatf("unexpected_result valid=%0b error=%0b", cmdValid, cmdError));
      end else begin
        monR = resQ.pop_front();
        check("result_error", {31'd0, cmdError}, {31'd0, monR.isError});
        check("result_valid", {31'd0, cmdValid}, {31'd0, !monR.isError});
        check("result_cycle", cyc, monR.cyc);
        check("speed", {22'd0, speed}, {22'd0, monR.speed});
        check("mode", {30'd0, mode}, {30'd0, monR.mode});
        check("stop", {31'd0, stop}, {31'd0, monR.stop});
        $display("result %s speed=%0h mode=%0d stop=%0b at cycle %0d",
                 cmdError ? "error" : "valid", speed, mode, stop, cyc);
      end
    end
    if (bus.transmit) begin
      if (holdTx) failNow("transmit_while_busy");
      if (prevTx) failNow("transmit_back_to_back");
      if (txQ.size() == 0) failNow($sformatf("unexpected_transmit tx_byte=%0h", bus.tx_byte));
      else check("tx_byte", {24'd0, bus.tx_byte}, {24'd0, txQ.pop_front()});
      $display("transmit tx_byte=%0h at cycle %0d", bus.tx_byte, cyc);
    end
    prevTx = bus.transmit;
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sendByte(input logic [7:0] b, output int c);
    c = cyc;
    bus.received = 1'b1;
    bus.rx_byte  = b;
    @(posedge clk); #1;
    bus.received = 1'b0;
    bus.rx_byte  = 8'($urandom);
  endtask

  // Reference model: whole-packet rules from the command table.
  task automatic modelPacket(input logic [7:0] cmd, dh, dl, chk, input int c);
    result_t r;
    bit ok;
    ok = (chk == (cmd ^ dh ^ dl)) && (cmd >= 8'd1) && (cmd <= 8'd3);
    if (ok) begin
      if (cmd == 8'd1) begin mSpeed = 10'((dh % 4) * 256 + dl); mStop = 1'b0; end
      else if (cmd == 8'd2) mMode = 2'(dl % 4);
      else begin mStop = 1'b1; mSpeed = 10'd0; end
    end
    r.isError = !ok;
    r.speed = mSpeed;
    r.mode = mMode;
    r.stop = mStop;
    r.cyc = c + 1;
    resQ.push_back(r);
    if (queueAck) txQ.push_back(ok ? 8'h06 : 8'h15);
  endtask

  task automatic sendPacket(input logic [7:0] cmd, dh, dl, chk, input int maxGap);
    logic [7:0] pkt[5];
    int c;
    pkt = '{8'hA5, cmd, dh, dl, chk};
    for (int i = 0; i < 5; i++) begin
      sendByte(pkt[i], c);
      if (i < 4) idle($urandom_range(maxGap, 0));
    end
    modelPacket(cmd, dh, dl, chk, c);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((resQ.size() != 0 || txQ.size() != 0 || uartBusy != 0 || bus.transmit) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) failNow("drain_timeout");
    idle(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] cmd, dh, dl, chk, g;
    reset = 1'b1;
    bus.received = 1'b0;
    bus.rx_byte = 8'h00;
    idle(3);
    check("rst_speed", {22'd0, speed}, 32'd0);
    check("rst_mode", {30'd0, mode}, 32'd0);
    check("rst_stop", {31'd0, stop}, 32'd1);
    check("rst_transmit", {31'd0, bus.transmit}, 32'd0);
    check("rst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    reset = 1'b0;
    idle(2);

    sendPacket(8'h01, 8'h01, 8'h2C, 8'h2C, 2);
    drain();
    check("speed_300", {22'd0, speed}, 32'd300);
    sendPacket(8'h01, 8'h03, 8'hFF, 8'hFD, 0);
    drain();
    sendPacket(8'h03, 8'h00, 8'h00, 8'h03, 1);
    drain();
    sendPacket(8'h02, 8'h00, 8'h02, 8'h00, 1);
    drain();
    sendPacket(8'h02, 8'h00, 8'h02, 8'h02, 1);
    drain();

    // Inter-byte timeout after SYNC, CMD.
    sendByte(8'hA5, c);
    sendByte(8'h01, c);
    begin
      result_t r;
      r.isError = 1'b1; r.speed = mSpeed; r.mode = mMode; r.stop = mStop; r.cyc = c + 1 + TO;
      resQ.push_back(r);
      txQ.push_back(8'h15);
    end
    idle(TO + 5);
    drain();
    sendPacket(8'h01, 8'h00, 8'h55, 8'h54, 2);
    drain();

    // Two results while the UART is held busy: only the latest ACK goes out.
    holdTx = 1'b1;
    queueAck = 1'b0;
    sendPacket(8'h02, 8'h00, 8'h01, 8'h03, 1);
    sendPacket(8'h01, 8'h02, 8'h10, 8'h13, 1);
    idle(10);
    txQ.push_back(8'h06);
    queueAck = 1'b1;
    holdTx = 1'b0;
    drain();
    idle(10);

    for (int p = 0; p < 40; p++) begin
      repeat ($urandom_range(2, 0)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        sendByte(g, c);
      end
      cmd = ($urandom_range(4, 0) < 3) ? 8'($urandom_range(3, 1)) : 8'($urandom);
      dh  = 8'($urandom);
      dl  = ($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom);
      chk = cmd ^ dh ^ dl;
      if ($urandom_range(4, 0) == 0) chk = chk ^ (8'd1 << $urandom_range(7, 0));
      sendPacket(cmd, dh, dl, chk, 3);
    end
    drain();

    // Reset in the middle of a packet.
    sendByte(8'hA5, c);
    sendByte(8'h01, c);
    sendByte(8'h00, c);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mSpeed = 10'd0; mMode = 2'd0; mStop = 1'b1;
    check("midrst_speed", {22'd0, speed}, 32'd0);
    check("midrst_mode", {30'd0, mode}, 32'd0);
    check("midrst_stop", {31'd0, stop}, 32'd1);
    check("midrst_tx_byte", {24'd0, bus.tx_byte}, 32'd0);
    check("midrst_valid", {31'd0, cmdValid}, 32'd0);
    sendByte(8'h64, c);
    sendByte(8'h65, c);
    idle(TO + 10);
    check("midrst_no_results", resQ.size(), 32'd0);
    sendPacket(8'h02, 8'h00, 8'h03, 8'h01, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
